// File: rtl/load_store_unit.sv
// Load/store unit bridging a DATAW-wide pipeline port to a byte-wide data memory.
// Transfers are sequenced one byte per cycle in big-endian order; misaligned requests are rejected.
module load_store_unit #(
    parameter int ADDRESSL = 32,
    parameter int DATAW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDRESSL-1:0] req_addr,
    input  logic [DATAW-1:0]    req_wdata,
    output logic                resp_valid,
    output logic [DATAW-1:0]    resp_rdata,
    output logic                resp_misaligned,
    output logic [ADDRESSL-1:0] mem_address,
    output logic [7:0]          mem_writeData,
    output logic                mem_memRead,
    output logic                mem_memWrite,
    input  logic [7:0]          mem_readData
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [ADDRESSL-1:0] ADDR_ONE = ADDRESSL'(1);

    state_t                state_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [1:0]            size_q;
    logic [1:0]            last_k_q;
    logic [1:0]            k_q;
    logic [31:0]           acc_q;
    logic [31:0]           wshift_q;
    logic                  resp_valid_q;
    logic [DATAW-1:0]      resp_rdata_q;
    logic                  resp_mis_q;
    logic [ADDRESSL-1:0]   mem_address_q;
    logic [7:0]            mem_wdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [31:0]           acc_d;

    function automatic logic is_misaligned(logic [1:0] sz, logic [1:0] lsb);
        return (sz == 2'b11) || (sz == 2'b01 && lsb[0]) || (sz == 2'b10 && lsb != 2'b00);
    endfunction

    function automatic logic [1:0] last_index(logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Store data is left-justified so the next byte to send is always bits [31:24].
    function automatic logic [31:0] left_justify(logic [31:0] d, logic [1:0] sz);
        case (sz)
            2'b00:   return {d[7:0], 24'h0};
            2'b01:   return {d[15:0], 16'h0};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATAW-1:0] extend(logic [31:0] v, logic [1:0] sz, logic uns);
        logic [DATAW-1:0] r;
        logic             s;
        case (sz)
            2'b00:   s = v[7];
            2'b01:   s = v[15];
            default: s = v[31];
        endcase
        r = {DATAW{s & ~uns}};
        case (sz)
            2'b00:   r[7:0]  = v[7:0];
            2'b01:   r[15:0] = v[15:0];
            default: r[31:0] = v;
        endcase
        return r;
    endfunction

    assign acc_d = {acc_q[23:0], mem_readData};

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            size_q        <= 2'b00;
            last_k_q      <= 2'd0;
            k_q           <= 2'd0;
            acc_q         <= '0;
            wshift_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_mis_q    <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        last_k_q   <= last_index(req_size);
                        k_q        <= 2'd0;
                        acc_q      <= '0;
                        wshift_q   <= left_justify(req_wdata[31:0], req_size);
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b1;
                        end else begin
                            state_q       <= XFER;
                            mem_address_q <= req_addr;
                            mem_read_q    <= ~req_write;
                            mem_write_q   <= req_write;
                            mem_wdata_q   <= req_write ? left_justify(req_wdata[31:0], req_size)[31:24] : 8'h00;
                        end
                    end
                end
                XFER: begin
                    if (!write_q) acc_q <= acc_d;
                    if (k_q == last_k_q) begin
                        state_q       <= DONE;
                        resp_valid_q  <= 1'b1;
                        resp_rdata_q  <= write_q ? '0 : extend(acc_d, size_q, unsigned_q);
                        mem_address_q <= '0;
                        mem_wdata_q   <= '0;
                        mem_read_q    <= 1'b0;
                        mem_write_q   <= 1'b0;
                    end else begin
                        k_q           <= k_q + 2'd1;
                        mem_address_q <= mem_address_q + ADDR_ONE;
                        wshift_q      <= wshift_q << 8;
                        mem_wdata_q   <= write_q ? wshift_q[23:16] : 8'h00;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so a reset landing mid-transfer
    // cuts the current strobe immediately rather than one edge later.
    assign req_ready       = (state_q == IDLE) && !rst;
    assign resp_valid      = resp_valid_q & ~rst;
    assign resp_rdata      = rst ? '0 : resp_rdata_q;
    assign resp_misaligned = resp_mis_q & ~rst;
    assign mem_address     = rst ? '0 : mem_address_q;
    assign mem_writeData   = rst ? '0 : mem_wdata_q;
    assign mem_memRead     = mem_read_q & ~rst;
    assign mem_memWrite    = mem_write_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven requests against a byte memory model,
// scoreboard of expected responses, plus reset-abort and back-to-back sequences.
module tb_load_store_unit;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          reads;
        int          writes;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          reads;
        int          writes;
        int          accept;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_address;
    logic [7:0]  mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [7:0]  mem_readData;

    logic [7:0]  mem [256] = '{default: 8'h00};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          bus_bad = 0;
    int          resp_bad = 0;
    exp_t        sb [$];
    vec_t        vecs [17];

    load_store_unit #(.ADDRESSL(32), .DATAW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) if (mem_memWrite) mem[mem_address[7:0]] <= mem_writeData;

    assign mem_readData = mem[mem_address[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(logic w, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic m, int lat, int r, int wr);
        vec_t v;
        v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.mis = m; v.lat = lat; v.reads = r; v.writes = wr;
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                rd_cnt += int'(mem_memRead);
                wr_cnt += int'(mem_memWrite);
            end
            if (!mem_memRead && !mem_memWrite && (mem_address != 0 || mem_writeData != 0)) bus_bad++;
            if (mem_memRead && mem_memWrite) bus_bad++;
            if (!resp_valid && (resp_rdata != 0 || resp_misaligned)) resp_bad++;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d with no request outstanding", cyc);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
                    check("latency", 32'(cyc - e.accept + 1), 32'(e.lat));
                    check("read_strobes", 32'(rd_cnt), 32'(e.reads));
                    check("write_strobes", 32'(wr_cnt), 32'(e.writes));
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    endtask

    // Called at a negedge; leaves req_valid high and returns at the negedge after acceptance.
    task automatic issue(input vec_t v, input bit track, output int accept, output int waits);
        exp_t e;
        req_write = v.write; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        waits = 0;
        accept = -1;
        while (!req_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            accept = cyc + 1;
            if (track) begin
                e.rdata = v.rdata; e.mis = v.mis; e.lat = v.lat;
                e.reads = v.reads; e.writes = v.writes; e.accept = accept;
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic release_req();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() > 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc_a, acc_b, w;
        vecs[0]  = mk(1, 2'b01, 0, 32'h20, 32'h0000_8001, 32'h0,         0, 3, 0, 2);
        vecs[1]  = mk(0, 2'b01, 0, 32'h20, 32'h0,         32'hFFFF_8001, 0, 3, 2, 0);
        vecs[2]  = mk(0, 2'b01, 1, 32'h20, 32'h0,         32'h0000_8001, 0, 3, 2, 0);
        vecs[3]  = mk(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 5, 0, 4);
        vecs[4]  = mk(0, 2'b10, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 5, 4, 0);
        vecs[5]  = mk(0, 2'b00, 0, 32'h13, 32'h0,         32'hFFFF_FFEF, 0, 2, 1, 0);
        vecs[6]  = mk(0, 2'b00, 1, 32'h13, 32'h0,         32'h0000_00EF, 0, 2, 1, 0);
        vecs[7]  = mk(0, 2'b01, 1, 32'h12, 32'h0,         32'h0000_BEEF, 0, 3, 2, 0);
        vecs[8]  = mk(0, 2'b10, 0, 32'h12, 32'h0,         32'h0,         1, 1, 0, 0);
        vecs[9]  = mk(1, 2'b01, 0, 32'h21, 32'hFFFF_FFFF, 32'h0,         1, 1, 0, 0);
        vecs[10] = mk(0, 2'b11, 0, 32'h30, 32'h0,         32'h0,         1, 1, 0, 0);
        vecs[11] = mk(1, 2'b00, 0, 32'h31, 32'h1234_5677, 32'h0,         0, 2, 0, 1);
        vecs[12] = mk(1, 2'b01, 0, 32'h32, 32'hFFFF_A5C3, 32'h0,         0, 3, 0, 2);
        vecs[13] = mk(0, 2'b10, 0, 32'h30, 32'h0,         32'h0077_A5C3, 0, 5, 4, 0);
        vecs[14] = mk(0, 2'b01, 0, 32'h20, 32'h0,         32'hFFFF_8001, 0, 3, 2, 0);
        vecs[15] = mk(0, 2'b00, 0, 32'h10, 32'h0,         32'hFFFF_FFDE, 0, 2, 1, 0);
        vecs[16] = mk(0, 2'b01, 0, 32'h30, 32'h0,         32'h0000_0077, 0, 3, 2, 0);

        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_strobes", 32'({mem_memRead, mem_memWrite}), 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1, acc_a, w);
            release_req();
            drain();
        end

        check("mem_0x10", 32'(mem[8'h10]), 32'hDE);
        check("mem_0x11", 32'(mem[8'h11]), 32'hAD);
        check("mem_0x12", 32'(mem[8'h12]), 32'hBE);
        check("mem_0x13", 32'(mem[8'h13]), 32'hEF);
        check("mem_0x21_untouched", 32'(mem[8'h21]), 32'h01);

        // Back-to-back: req_valid held high, second request waits out XFER and DONE.
        issue(vecs[6], 1'b1, acc_a, w);
        check("ready_low_xfer", 32'(req_ready), 32'd0);
        issue(vecs[15], 1'b1, acc_b, w);
        check("b2b_wait_cycles", 32'(w), 32'd2);
        check("b2b_accept_spacing", 32'(acc_b - acc_a), 32'd3);
        release_req();
        drain();

        // Reset during the second XFER cycle of a word store.
        issue(mk(1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 5, 0, 4), 1'b0, acc_a, w);
        release_req();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cuts_strobe", 32'(mem_memWrite), 32'd0);
        check("rst_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_abort", 32'(req_ready), 32'd1);
        repeat (8) @(negedge clk);
        check("abort_mem_0x40", 32'(mem[8'h40]), 32'hDE);
        check("abort_mem_0x41", 32'(mem[8'h41]), 32'h00);
        check("abort_mem_0x43", 32'(mem[8'h43]), 32'h00);

        check("idle_bus_quiet", 32'(bus_bad), 32'd0);
        check("resp_fields_zero", 32'(resp_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
